// File: rtl/acc_pkg.sv
// Shared defaults and FSM state type for the FIR sequencing controller.
package acc_pkg;

  localparam int ACC_IW    = 12;
  localparam int ACC_OW    = 2 * ACC_IW + 7;
  localparam int ACC_DEPTH = 8;
  localparam int ACC_PRIME = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

endpackage

// File: rtl/acc_sync_fifo.sv
// Synchronous FIFO with level output and synchronous clear; DEPTH must be a power of 2.
module acc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so push-while-full succeeds then.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every reader sees pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is not reset; the pointers and level alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequences samples from an input FIFO into an external FIR one at a time and
// stores its results in an output FIFO, discarding the first PRIME as pipeline fill.
module fir_seq_ctrl
  import acc_pkg::*;
#(
  parameter int IW    = ACC_IW,
  parameter int OW    = ACC_OW,
  parameter int DEPTH = ACC_DEPTH,
  parameter int PRIME = ACC_PRIME
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          wr_valid,
  input  logic [IW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          rd_req,
  output logic [OW-1:0] rd_data,
  output logic          rd_valid,
  output logic          fir_ce,
  output logic [IW-1:0] fir_sample,
  input  logic [OW-1:0] fir_result,
  input  logic          flush,
  input  logic [2:0]    thresh,
  output logic          irq,
  output logic [31:0]   cnt_in,
  output logic [31:0]   cnt_out,
  output logic [3:0]    status
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(PRIME + 1);

  state_e        state_q, state_d;
  logic [PW-1:0] prime_q, prime_d;
  logic [31:0]   cnt_in_q, cnt_in_d;
  logic [31:0]   cnt_out_q, cnt_out_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          irq_q, irq_d;
  logic [IW-1:0] fir_sample_q, fir_sample_d;

  logic          in_push, in_pop, in_full, in_empty;
  logic [IW-1:0] in_rdata;
  logic [LW-1:0] in_level;
  logic          out_push, out_pop, out_full, out_empty;
  logic [LW-1:0] out_level;
  logic          primed, busy;

  assign in_push = wr_valid && wr_ready;
  assign out_pop = rd_req && rd_valid;

  acc_sync_fifo #(.WIDTH(IW), .DEPTH(DEPTH), .LW(LW)) u_in_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .clr   (flush),
    .push  (in_push),
    .pop   (in_pop),
    .wdata (wr_data),
    .rdata (in_rdata),
    .full  (in_full),
    .empty (in_empty),
    .level (in_level)
  );

  acc_sync_fifo #(.WIDTH(OW), .DEPTH(DEPTH), .LW(LW)) u_out_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .clr   (flush),
    .push  (out_push),
    .pop   (out_pop),
    .wdata (fir_result),
    .rdata (rd_data),
    .full  (out_full),
    .empty (out_empty),
    .level (out_level)
  );

  assign wr_ready   = !in_full;
  assign rd_valid   = !out_empty;
  assign primed     = (prime_q == PW'(PRIME));
  assign busy       = (state_q != ST_IDLE) || (in_level != '0);
  assign status     = {busy, primed, ovf_q, unf_q};
  assign irq        = irq_q;
  assign cnt_in     = cnt_in_q;
  assign cnt_out    = cnt_out_q;
  assign fir_sample = (state_q == ST_ISSUE) ? in_rdata : fir_sample_q;

  always_comb begin
    state_d      = state_q;
    prime_d      = prime_q;
    cnt_in_d     = cnt_in_q;
    cnt_out_d    = cnt_out_q;
    ovf_d        = ovf_q || (wr_valid && in_full);
    unf_d        = unf_q || (rd_req && out_empty);
    irq_d        = (thresh != 3'd0) && (out_level >= LW'(thresh));
    fir_sample_d = fir_sample_q;
    fir_ce       = 1'b0;
    in_pop       = 1'b0;
    out_push     = 1'b0;

    case (state_q)
      // Once primed, a full output FIFO holds the next issue back so no result is lost.
      ST_IDLE: begin
        if (!in_empty && (!out_full || !primed)) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        fir_ce       = 1'b1;
        in_pop       = 1'b1;
        fir_sample_d = in_rdata;
        cnt_in_d     = cnt_in_q + 32'd1;
        state_d      = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!primed) begin
          prime_d = prime_q + PW'(1);
        end else begin
          out_push  = 1'b1;
          cnt_out_d = cnt_out_q + 32'd1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush wins over any concurrent transfer or transition; counters keep their value.
    if (flush) begin
      state_d   = ST_IDLE;
      prime_d   = '0;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
      cnt_in_d  = cnt_in_q;
      cnt_out_d = cnt_out_q;
      in_pop    = 1'b0;
      out_push  = 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q      <= ST_IDLE;
      prime_q      <= '0;
      cnt_in_q     <= '0;
      cnt_out_q    <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      irq_q        <= 1'b0;
      fir_sample_q <= '0;
    end else begin
      state_q      <= state_d;
      prime_q      <= prime_d;
      cnt_in_q     <= cnt_in_d;
      cnt_out_q    <= cnt_out_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      irq_q        <= irq_d;
      fir_sample_q <= fir_sample_d;
    end
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl: cycle table for priming, then hand sequences
// for backpressure, overflow/underflow, irq, flush, counter wrap and mid-run reset.
module tb_fir_seq_ctrl;

  localparam int IW = 12;
  localparam int OW = 31;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          wr_valid, rd_req, flush;
  logic [IW-1:0] wr_data;
  logic [2:0]    thresh;
  logic          wr_ready, rd_valid, fir_ce, irq;
  logic [OW-1:0] rd_data, fir_result;
  logic [IW-1:0] fir_sample;
  logic [31:0]   cnt_in, cnt_out;
  logic [3:0]    status;

  fir_seq_ctrl dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .rd_req     (rd_req),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fir_ce     (fir_ce),
    .fir_sample (fir_sample),
    .fir_result (fir_result),
    .flush      (flush),
    .thresh     (thresh),
    .irq        (irq),
    .cnt_in     (cnt_in),
    .cnt_out    (cnt_out),
    .status     (status)
  );

  always #5 HCLK = ~HCLK;

  // External FIR, taps 1,2,3,2,1, advancing on each fir_ce.
  int hist [5];
  int ce_count = 0;
  always @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int i = 0; i < 5; i++) hist[i] <= 0;
    end else if (fir_ce) begin
      hist[0] <= int'(fir_sample);
      for (int i = 1; i < 5; i++) hist[i] <= hist[i-1];
    end
    if (fir_ce) ce_count <= ce_count + 1;
  end
  always_comb fir_result = OW'(hist[0] + 2 * hist[1] + 3 * hist[2] + 2 * hist[3] + hist[4]);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  int xs [14];

  function automatic int fir_ref(input int n);
    return xs[n] + 2 * xs[n-1] + 3 * xs[n-2] + 2 * xs[n-3] + xs[n-4];
  endfunction

  task automatic push_sample(input logic [IW-1:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge HCLK);
    wr_valid = 1'b0;
  endtask

  task automatic wait_ce(input string name);
    for (int i = 0; i < 12 && !fir_ce; i++) @(negedge HCLK);
    check(name, 32'(fir_ce), 32'd1);
  endtask

  task automatic wait_cnt_out(input logic [31:0] target, input string name);
    for (int i = 0; i < 100 && cnt_out != target; i++) @(negedge HCLK);
    check(name, cnt_out, target);
  endtask

  typedef struct {
    logic          wv;
    logic [IW-1:0] wd;
    logic          ce;
    logic [IW-1:0] smp;
    logic [3:0]    st;
    logic [31:0]   ci;
  } vec_t;

  vec_t vecs [17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] ci_snap, co_snap;
    int          ce_snap;

    xs = '{10, 20, 30, 40, 50, 101, 202, 303, 404, 505, 606, 707, 808, 909};

    // Cycle-by-cycle priming: 5 writes, ISSUE every third cycle, results discarded.
    vecs[0]  = '{1'b1, 12'd10, 1'b0, 12'd0,  4'h0, 32'd0};
    vecs[1]  = '{1'b1, 12'd20, 1'b0, 12'd0,  4'h8, 32'd0};
    vecs[2]  = '{1'b1, 12'd30, 1'b1, 12'd10, 4'h8, 32'd0};
    vecs[3]  = '{1'b1, 12'd40, 1'b0, 12'd10, 4'h8, 32'd1};
    vecs[4]  = '{1'b1, 12'd50, 1'b0, 12'd10, 4'h8, 32'd1};
    vecs[5]  = '{1'b0, 12'd0,  1'b1, 12'd20, 4'h8, 32'd1};
    vecs[6]  = '{1'b0, 12'd0,  1'b0, 12'd20, 4'h8, 32'd2};
    vecs[7]  = '{1'b0, 12'd0,  1'b0, 12'd20, 4'h8, 32'd2};
    vecs[8]  = '{1'b0, 12'd0,  1'b1, 12'd30, 4'h8, 32'd2};
    vecs[9]  = '{1'b0, 12'd0,  1'b0, 12'd30, 4'h8, 32'd3};
    vecs[10] = '{1'b0, 12'd0,  1'b0, 12'd30, 4'h8, 32'd3};
    vecs[11] = '{1'b0, 12'd0,  1'b1, 12'd40, 4'h8, 32'd3};
    vecs[12] = '{1'b0, 12'd0,  1'b0, 12'd40, 4'h8, 32'd4};
    vecs[13] = '{1'b0, 12'd0,  1'b0, 12'd40, 4'h8, 32'd4};
    vecs[14] = '{1'b0, 12'd0,  1'b1, 12'd50, 4'h8, 32'd4};
    vecs[15] = '{1'b0, 12'd0,  1'b0, 12'd50, 4'h8, 32'd5};
    vecs[16] = '{1'b0, 12'd0,  1'b0, 12'd50, 4'h4, 32'd5};

    wr_valid = 1'b0;
    wr_data  = '0;
    rd_req   = 1'b0;
    flush    = 1'b0;
    thresh   = 3'd0;
    HRESETn  = 1'b0;
    repeat (3) @(negedge HCLK);

    check("rst_wr_ready",   32'(wr_ready),   32'd1);
    check("rst_rd_valid",   32'(rd_valid),   32'd0);
    check("rst_status",     32'(status),     32'd0);
    check("rst_fir_ce",     32'(fir_ce),     32'd0);
    check("rst_fir_sample", 32'(fir_sample), 32'd0);
    check("rst_cnt_in",     cnt_in,          32'd0);
    check("rst_cnt_out",    cnt_out,         32'd0);
    check("rst_irq",        32'(irq),        32'd0);
    HRESETn = 1'b1;

    for (int k = 0; k < 17; k++) begin
      wr_valid = vecs[k].wv;
      wr_data  = vecs[k].wd;
      #1;
      check($sformatf("v%0d_fir_ce", k),     32'(fir_ce),     32'(vecs[k].ce));
      check($sformatf("v%0d_fir_sample", k), 32'(fir_sample), 32'(vecs[k].smp));
      check($sformatf("v%0d_status", k),     32'(status),     32'(vecs[k].st));
      check($sformatf("v%0d_cnt_in", k),     cnt_in,          vecs[k].ci);
      check($sformatf("v%0d_cnt_out", k),    cnt_out,         32'd0);
      check($sformatf("v%0d_rd_valid", k),   32'(rd_valid),   32'd0);
      @(negedge HCLK);
    end

    // Backpressure: 9 samples, output FIFO fills at 8, the 9th waits in the input FIFO.
    for (int j = 0; j < 9; j++) push_sample(IW'(xs[5+j]));
    wait_cnt_out(32'd8, "bp_fill_out");
    repeat (6) @(negedge HCLK);
    check("bp_ce_total", 32'(ce_count),  32'd13);
    check("bp_cnt_in",   cnt_in,         32'd13);
    check("bp_status",   32'(status),    32'hC);
    check("bp_rd_valid", 32'(rd_valid),  32'd1);
    check("bp_head",     32'(rd_data),   32'(fir_ref(5)));
    rd_req = 1'b1;
    @(negedge HCLK);
    rd_req = 1'b0;
    wait_cnt_out(32'd9, "bp_resume_store");
    check("bp_ce_after_read", 32'(ce_count), 32'd14);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d_data", i), 32'(rd_data), 32'(fir_ref(6 + i)));
      rd_req = 1'b1;
      @(negedge HCLK);
    end
    rd_req = 1'b0;
    #1;
    check("drain_rd_valid", 32'(rd_valid), 32'd0);
    check("drain_status",   32'(status),   32'h4);

    // Overflow: output full and primed, so 8 writes fill the input FIFO and the 9th drops.
    for (int j = 0; j < 8; j++) push_sample(12'h3A5);
    wait_cnt_out(32'd17, "ovf_fill_out");
    wr_valid = 1'b1;
    wr_data  = 12'h5C3;
    repeat (8) @(negedge HCLK);
    check("ovf_wr_ready_full", 32'(wr_ready), 32'd0);
    check("ovf_status_pre",    32'(status),   32'hC);
    @(negedge HCLK);
    wr_valid = 1'b0;
    check("ovf_status",        32'(status),   32'hE);
    check("ovf_cnt_in",        cnt_in,        32'd22);

    flush = 1'b1;
    @(negedge HCLK);
    flush = 1'b0;
    #1;
    check("flush_status",   32'(status),   32'h0);
    check("flush_rd_valid", 32'(rd_valid), 32'd0);
    check("flush_wr_ready", 32'(wr_ready), 32'd1);
    check("flush_cnt_in",   cnt_in,        32'd22);
    check("flush_cnt_out",  cnt_out,       32'd17);

    rd_req = 1'b1;
    @(negedge HCLK);
    rd_req = 1'b0;
    check("unf_status", 32'(status), 32'h1);

    // irq at threshold 3: re-prime with 5 samples, then 3 stored results.
    thresh = 3'd3;
    for (int j = 0; j < 8; j++) push_sample(IW'(j + 1));
    wait_cnt_out(32'd20, "irq_third_push");
    check("irq_lag_rise", 32'(irq), 32'd0);
    rd_req = 1'b1;
    @(negedge HCLK);
    rd_req = 1'b0;
    check("irq_high", 32'(irq), 32'd1);
    @(negedge HCLK);
    check("irq_lag_fall", 32'(irq), 32'd0);

    // Flush in CAPTURE with a coincident write while primed.
    thresh = 3'd0;
    push_sample(12'h0F0);
    wait_ce("cap_flush_issue");
    @(negedge HCLK);
    ci_snap  = cnt_in;
    co_snap  = cnt_out;
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 12'h0AA;
    @(negedge HCLK);
    flush    = 1'b0;
    wr_valid = 1'b0;
    #1;
    check("cap_flush_status",   32'(status),   32'h0);
    check("cap_flush_rd_valid", 32'(rd_valid), 32'd0);
    check("cap_flush_cnt_in",   cnt_in,        ci_snap);
    check("cap_flush_cnt_out",  cnt_out,       co_snap);
    check("cap_flush_cnt_in_v", cnt_in,        32'd31);
    ce_snap = ce_count;
    repeat (6) @(negedge HCLK);
    check("cap_flush_write_dropped", 32'(ce_count), 32'(ce_snap));

    // cnt_in wrap.
    force dut.cnt_in_d = 32'hFFFF_FFFF;
    @(negedge HCLK);
    release dut.cnt_in_d;
    #1;
    check("wrap_pre", cnt_in, 32'hFFFF_FFFF);
    push_sample(12'h123);
    wait_ce("wrap_issue");
    @(negedge HCLK);
    check("wrap_cnt_in", cnt_in, 32'd0);

    // Reset during CAPTURE aborts the in-flight sample.
    push_sample(12'h456);
    wait_ce("midrst_issue");
    @(negedge HCLK);
    HRESETn = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    #1;
    check("midrst_status",     32'(status),     32'h0);
    check("midrst_cnt_in",     cnt_in,          32'd0);
    check("midrst_cnt_out",    cnt_out,         32'd0);
    check("midrst_rd_valid",   32'(rd_valid),   32'd0);
    check("midrst_wr_ready",   32'(wr_ready),   32'd1);
    check("midrst_fir_sample", 32'(fir_sample), 32'd0);
    ce_snap = ce_count;
    repeat (6) @(negedge HCLK);
    check("midrst_idle", 32'(ce_count), 32'(ce_snap));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_seq_ctrl.md
FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 Parameters SHALL be: IW 12, sample width; OW 31, result width (2*IW+7); DEPTH 8, entries per FIFO (power of 2); PRIME 5, results discarded after reset/flush (pipeline fill).
REQ-002 One clock; reset is synchronous and active-low; ports SHALL be: HCLK in 1, clock; HRESETn in 1, synchronous active-low reset.
REQ-003 wr_valid in 1, sample write strobe; wr_data in IW, sample; wr_ready out 1, input FIFO not full.
REQ-004 rd_req in 1, result pop strobe; rd_data out OW, head of output FIFO; rd_valid out 1, output FIFO not empty.
REQ-005 fir_ce out 1, FIR clock-enable pulse; fir_sample out IW, sample presented with fir_ce; fir_result in OW, FIR accumulator output.
REQ-006 flush in 1, clear request; thresh in 3, irq level; irq out 1, output level >= thresh and thresh != 0.
REQ-007 cnt_in out 32, samples issued; cnt_out out 32, results stored; status out 4, {busy, primed, ovf, unf}.

Function
REQ-008 Input FIFO SHALL push wr_data when wr_valid && wr_ready; a write while full SHALL be dropped and set sticky ovf.
REQ-009 FSM SHALL have states IDLE, ISSUE, CAPTURE.
REQ-010 IDLE -> ISSUE when input FIFO non-empty and (output FIFO not full or primed=0); otherwise remain IDLE.
REQ-011 ISSUE SHALL last exactly one cycle: fir_ce=1, fir_sample=input head, input FIFO popped, cnt_in incremented; -> CAPTURE.
REQ-012 CAPTURE SHALL last one cycle: if prime count < PRIME, discard fir_result and increment prime count; else push fir_result to output FIFO and increment cnt_out; -> IDLE.
REQ-013 primed SHALL be 1 when prime count == PRIME; prime count SHALL saturate at PRIME.
REQ-014 fir_ce SHALL be 0 in IDLE and CAPTURE; fir_sample SHALL hold its last value outside ISSUE.
REQ-015 Latency: wr_valid accepted at edge N into empty idle block -> fir_ce high in cycle N+2 -> result stored (if primed) at end of cycle N+3; throughput one sample per 3 cycles.
REQ-016 Output FIFO full and primed SHALL stall in IDLE (backpressure); no result SHALL ever be lost or overwritten.
REQ-017 rd_data SHALL be combinational FIFO head; rd_req && rd_valid pops; rd_req while empty SHALL be ignored and set sticky unf.
REQ-018 Simultaneous push and pop on either FIFO SHALL both occur, level unchanged; including full (input: pop by ISSUE frees space same edge only if wr_ready was derived pre-edge: write while full SHALL still drop).
REQ-019 Pointers SHALL wrap modulo DEPTH; level SHALL be 0..DEPTH inclusive.
REQ-020 flush SHALL, at the next edge, empty both FIFOs, clear prime count, ovf, unf, force IDLE; counters SHALL NOT clear; flush overrides a coincident write/read/state transition.
REQ-021 busy SHALL be 1 when state != IDLE or input FIFO non-empty.
REQ-022 cnt_in/cnt_out SHALL wrap 0xFFFFFFFF -> 0.
REQ-023 irq SHALL be registered, updating one cycle after level change.

Reset
REQ-024 On HCLK rising edge with HRESETn=0: state IDLE, FIFOs empty, prime count 0, cnt_in=cnt_out=0, ovf=unf=0, fir_ce=0, fir_sample=0, irq=0; hence wr_ready=1, rd_valid=0, status=0.
REQ-025 Reset mid-operation (ISSUE or CAPTURE) SHALL abort; the in-flight result SHALL NOT be stored.

Structure
REQ-026 Package acc_pkg SHALL hold IW/OW defaults, DEPTH, PRIME and the FSM state enum.
REQ-027 One sub-module acc_sync_fifo (parameterised width/depth, push/pop/full/empty/level, synchronous clear) SHALL be instantiated twice.

Verification
REQ-028 Reset, write 5 samples, no reads -> 5 fir_ce pulses 3 cycles apart, cnt_in=5, cnt_out=0, primed=1, rd_valid=0.
REQ-029 After priming, write 8 samples with FIR model (taps 1,2,3,2,1), no reads -> output full, 9th sample held in input FIFO, fir_ce stops, busy=1; one read -> one more ce issued.
REQ-030 Hold wr_valid with input full and no issue possible -> 9th write dropped, ovf=1; rd_req while empty -> unf=1.
REQ-031 thresh=3: store 3 results -> irq rises one cycle after third push; read one -> irq falls one cycle later.
REQ-032 flush asserted in CAPTURE with write coincident -> both FIFOs empty, primed=0, state IDLE, write dropped, counters unchanged.
REQ-033 Drive cnt_in to 0xFFFFFFFF via force, issue one sample -> cnt_in=0.
